// File: rtl/aes128_key_expand_pkg.sv
// Shared AES definitions: word and round-key types, FSM states, S-box and Rcon.
package aes128_key_expand_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] rkey_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } state_t;

  localparam int NUM_RK = 11;

  // Forward S-box; entry 0 sits in the most significant byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Round constants indexed by round number; entry 0 is unused.
  localparam logic [0:10][7:0] RCON = {
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/aes128_key_expand_if.sv
// Key-schedule bus: start/key request, status flags and round-key read port.
interface aes128_key_expand_if;
  import aes128_key_expand_pkg::*;

  logic       start;
  rkey_t      key;
  logic       busy;
  logic       done;
  logic       keys_valid;
  logic [3:0] rk_idx;
  rkey_t      rk_out;

  modport master (
    output start, key, rk_idx,
    input  busy, done, keys_valid, rk_out
  );

  modport slave (
    input  start, key, rk_idx,
    output busy, done, keys_valid, rk_out
  );

endinterface

// File: rtl/aes128_key_expand_sub_word.sv
// Combinational SubWord: S-box substitution of each byte of a 32-bit word.
module aes128_key_expand_sub_word
  import aes128_key_expand_pkg::*;
(
  input  word_t din,
  output word_t dout
);

  assign dout = {sbox(din[31:24]), sbox(din[23:16]), sbox(din[15:8]), sbox(din[7:0])};

endmodule

// File: rtl/aes128_key_expand.sv
// Sequential AES-128 key schedule: one round key per clock into an 11-entry file.
module aes128_key_expand
  import aes128_key_expand_pkg::*;
#(
  parameter int NUM_ROUNDS = 10
)
(
  input logic                clk,
  input logic                rst,
  aes128_key_expand_if.slave bus
);

  if (NUM_ROUNDS != 10) begin : g_bad_rounds
    $error("aes128_key_expand supports only NUM_ROUNDS = 10");
  end

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  state_t     state_q, state_d;
  logic [3:0] rnd_q, rnd_d;
  logic       done_q, done_d;
  logic       kv_q, kv_d;
  logic       wr_en;
  logic [3:0] wr_idx;
  rkey_t      wr_data;
  rkey_t      rk_q [NUM_RK];

  logic [3:0] prev_idx;
  rkey_t      prev_rk;
  word_t      rot_w, sub_w, t_w;
  word_t      n0, n1, n2, n3;

  // Previous round key; rnd is 0 only outside an expansion, where the value is unused.
  assign prev_idx = (rnd_q == 4'd0) ? 4'd0 : rnd_q - 4'd1;
  assign prev_rk  = rk_q[prev_idx];
  assign rot_w    = {prev_rk[23:0], prev_rk[31:24]};

  aes128_key_expand_sub_word u_sub_word (
    .din  (rot_w),
    .dout (sub_w)
  );

  assign t_w = sub_w ^ {RCON[rnd_q], 24'h000000};
  assign n0  = prev_rk[127:96] ^ t_w;
  assign n1  = prev_rk[95:64]  ^ n0;
  assign n2  = prev_rk[63:32]  ^ n1;
  assign n3  = prev_rk[31:0]   ^ n2;

  // Next-state, round counter, status flags and register-file write selection.
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    done_d  = 1'b0;
    kv_d    = kv_q;
    wr_en   = 1'b0;
    wr_idx  = rnd_q;
    wr_data = {n0, n1, n2, n3};
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_EXPAND;
          rnd_d   = 4'd1;
          kv_d    = 1'b0;
          wr_en   = 1'b1;
          wr_idx  = 4'd0;
          wr_data = bus.key;
        end
      end
      ST_EXPAND: begin
        wr_en = 1'b1;
        if (rnd_q == LAST_RND) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          kv_d    = 1'b1;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers; reset aborts any expansion in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      rnd_q   <= 4'd0;
      done_q  <= 1'b0;
      kv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      done_q  <= done_d;
      kv_q    <= kv_d;
    end
  end

  // Round-key register file, cleared on reset so stale keys never leak out.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_RK; i++) rk_q[i] <= '0;
    end else if (wr_en) begin
      rk_q[wr_idx] <= wr_data;
    end
  end

  assign bus.busy       = (state_q == ST_EXPAND);
  assign bus.done       = done_q;
  assign bus.keys_valid = kv_q;
  assign bus.rk_out     = (bus.rk_idx <= 4'd10) ? rk_q[bus.rk_idx] : '0;

endmodule

// File: tb/tb_aes128_key_expand.sv
// Scoreboard bench for the AES-128 key schedule with a word-wise reference model.
module tb_aes128_key_expand;

  logic clk = 1'b0;
  logic rst;

  aes128_key_expand_if bus_if ();

  aes128_key_expand #(.NUM_ROUNDS(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #20 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1407:0] rks;
    int            due;
    logic [2:0]    ref_mask;
    logic [127:0]  ref0;
    logic [127:0]  ref1;
    logic [127:0]  ref10;
  } exp_t;

  exp_t sb[$];

  int flush_req  = 0;
  int flush_seen = 0;
  int clear_req  = 0;
  int clear_seen = 0;
  int n_done     = 0;
  int n_push     = 0;

  task automatic chk128(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chkint(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: S-box derived from GF(2^8) inverse + affine map, FIPS word recurrence.
  logic [7:0] sbox_m [256];

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  task automatic init_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [1407:0] model_expand(input logic [127:0] k);
    logic [31:0]   w [44];
    logic [31:0]   tmp;
    logic [7:0]    rc;
    logic [1407:0] r;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]]}
              ^ {rc, 24'h000000};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int j = 0; j < 11; j++) r[j*128 +: 128] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Monitor: owns rk_idx, pops the scoreboard whenever an expansion is due.
  initial begin
    exp_t cur;
    bus_if.rk_idx = 4'd0;
    forever begin
      @(negedge clk);
      if (flush_req != flush_seen) begin
        flush_seen = flush_req;
        sb.delete();
      end
      if (clear_req != clear_seen) begin
        clear_seen = clear_req;
        chk1("rst_busy", bus_if.busy, 1'b0);
        chk1("rst_done", bus_if.done, 1'b0);
        chk1("rst_keys_valid", bus_if.keys_valid, 1'b0);
        for (int i = 0; i < 11; i++) begin
          bus_if.rk_idx = 4'(i);
          #1;
          chk128($sformatf("rst_rk%0d", i), bus_if.rk_out, 128'd0);
        end
      end
      if (sb.size() != 0) begin
        if (cyc < sb[0].due) begin
          chk1("exp_busy", bus_if.busy, 1'b1);
          chk1("exp_done_early", bus_if.done, 1'b0);
          chk1("exp_keys_valid", bus_if.keys_valid, 1'b0);
        end else begin
          cur = sb.pop_front();
          n_done++;
          chk1("done_pulse", bus_if.done, 1'b1);
          chk1("done_busy", bus_if.busy, 1'b0);
          chk1("done_keys_valid", bus_if.keys_valid, 1'b1);
          for (int i = 0; i < 11; i++) begin
            bus_if.rk_idx = 4'(i);
            #1;
            chk128($sformatf("rk%0d", i), bus_if.rk_out, cur.rks[i*128 +: 128]);
            if (i == 0 && cur.ref_mask[0])  chk128("fips_rk0", bus_if.rk_out, cur.ref0);
            if (i == 1 && cur.ref_mask[1])  chk128("fips_rk1", bus_if.rk_out, cur.ref1);
            if (i == 10 && cur.ref_mask[2]) chk128("fips_rk10", bus_if.rk_out, cur.ref10);
          end
          bus_if.rk_idx = 4'd11;
          #1;
          chk128("rk_idx11_zero", bus_if.rk_out, 128'd0);
          bus_if.rk_idx = 4'd15;
          #1;
          chk128("rk_idx15_zero", bus_if.rk_out, 128'd0);
        end
      end else begin
        chk1("idle_busy", bus_if.busy, 1'b0);
        chk1("idle_done", bus_if.done, 1'b0);
      end
    end
  end

  // Issues a start at the next falling edge and queues the expected schedule.
  task automatic start_exp(input logic [127:0] k, input logic [2:0] mask,
                           input logic [127:0] r0, input logic [127:0] r1,
                           input logic [127:0] r10, output int t);
    exp_t e;
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.key   = k;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    t            = cyc;
    e.rks        = model_expand(k);
    e.due        = t + 10;
    e.ref_mask   = mask;
    e.ref0       = r0;
    e.ref1       = r1;
    e.ref10      = r10;
    sb.push_back(e);
    n_push++;
  endtask

  // Waits to the falling edge where cyc reaches c, scrambling the key input each cycle.
  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(negedge clk);
      bus_if.key = rand128();
    end
  endtask

  localparam logic [127:0] K_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] F_RK1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] F_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K_SEQ   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] S_RK10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] Z_RK1   = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_RK10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  // Stimulus: directed FIPS cases, overlap/reset/back-to-back scenarios, random keys.
  initial begin
    int t;
    int t2;
    init_sbox();
    rst           = 1'b0;
    bus_if.start  = 1'b0;
    bus_if.key    = '0;
    clear_req     = clear_req + 1;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    start_exp(K_FIPS, 3'b111, K_FIPS, F_RK1, F_RK10, t);
    wait_until(t + 12);
    start_exp(K_SEQ, 3'b101, K_SEQ, '0, S_RK10, t);
    wait_until(t + 11);
    start_exp('0, 3'b111, '0, Z_RK1, Z_RK10, t);
    wait_until(t + 12);

    // Second start four edges in must be ignored.
    start_exp(K_FIPS, 3'b111, K_FIPS, F_RK1, F_RK10, t);
    wait_until(t + 3);
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.key   = 128'hdeadbeef0123456789abcdeffedcba98;
    @(negedge clk);
    bus_if.start = 1'b0;
    wait_until(t + 13);

    // Reset sampled five edges into an expansion.
    start_exp(rand128(), 3'b000, '0, '0, '0, t);
    wait_until(t + 4);
    rst = 1'b0;
    @(posedge clk);
    #1;
    flush_req = flush_req + 1;
    clear_req = clear_req + 1;
    @(negedge clk);
    rst = 1'b1;
    start_exp(K_FIPS, 3'b111, K_FIPS, F_RK1, F_RK10, t);
    wait_until(t + 11);

    // Back-to-back: new start driven in the cycle done is high.
    start_exp(rand128(), 3'b000, '0, '0, '0, t);
    wait_until(t + 9);
    start_exp(K_SEQ, 3'b101, K_SEQ, '0, S_RK10, t2);
    chkint("b2b_start_edge", t2, t + 11);
    wait_until(t2 + 9);

    for (int n = 0; n < 6; n++) begin
      start_exp(rand128(), 3'b000, '0, '0, '0, t);
      wait_until(t + 9 + int'($urandom_range(0, 3)));
    end
    wait_until(cyc + 14);

    chkint("scoreboard_drained", sb.size(), 0);
    chkint("done_count", n_done, n_push - 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes128_key_expand.md
Name: aes128_key_expand

Overview:
- Sequential AES-128 key schedule (FIPS-197). Sits directly upstream of the AES-128 round datapath and feeds it one 128-bit round key per round.
- Latches a cipher key on a start pulse and computes one full round key (4 words) per clock.
- Stores all 11 round keys in a register file that the round datapath reads by round index.
- Replaces the cipher's combinational, sensitivity-list-driven expansion with a clocked, handshaked stage.

Parameters:
- NUM_ROUNDS, 10, number of expanded rounds. Only 10 (AES-128) is supported; any other value is a synthesis-time error.

Ports:
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  synchronous, active-low reset
- start  input  1  request expansion of key; sampled only in IDLE
- key  input  128  cipher key, word 0 = key[127:96]; sampled on the start edge only
- busy  output  1  high while expansion is in progress
- done  output  1  single-cycle pulse when all round keys are written
- keys_valid  output  1  high when rk[0..10] all belong to the last latched key
- rk_idx  input  4  round-key read index, 0..10
- rk_out  output  128  round key rk_idx; combinational read, {W[4i],W[4i+1],W[4i+2],W[4i+3]}

Behaviour:
- Reset (rst=0 at an edge):
  - state=IDLE, rnd=0, busy=0, done=0, keys_valid=0.
  - All 11 rk entries cleared to 0.
  - Reset dominates start and applies mid-expansion, aborting it.
- FSM states: IDLE, EXPAND.
- IDLE, on an edge with start=1:
  - rk[0]<=key, rnd<=1, busy<=1, keys_valid<=0, state<=EXPAND.
- IDLE, on an edge with start=0: hold all state.
- EXPAND, each edge:
  - Prev = rk[rnd-1] = {w0,w1,w2,w3}.
  - t = SubWord(RotWord(w3)) ^ Rcon[rnd]. RotWord is a left byte rotate: {b0,b1,b2,b3} -> {b1,b2,b3,b0}.
  - n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2; rk[rnd]<={n0,n1,n2,n3}.
  - If rnd==10: state<=IDLE, busy<=0, done<=1, keys_valid<=1.
  - Otherwise: rnd<=rnd+1.
- Latency: start sampled at edge T; done and keys_valid are high after edge T+10 (10 cycles). done drops after edge T+11 unless a new expansion completes.
- done is a one-cycle pulse. It is low in every cycle except the one following the final write.
- start while busy is ignored: no restart, no queuing, key not resampled.
- start in IDLE while keys_valid=1 begins a new expansion; keys_valid drops on that same edge.
- rk_idx > 10 returns rk_out = 0.
- Reads during EXPAND return current register contents, which may be stale or partial. Consumers must gate on keys_valid.
- The key input may change freely after the start edge.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36, placed in the MSByte of the 32-bit word.
- rnd is 4 bits and never exceeds 10; no wrap-around is reachable.

Decomposition:
- Shared package aes_pkg:
  - 256-entry S-box constant.
  - Rcon array.
  - FSM state enum.
  - Round-key type (128-bit) and word type (32-bit).
- Natural sub-module aes_sub_word: combinational 4-byte S-box substitution of a 32-bit word. Reused by the cipher's SubBytes stage (4 instances).

Test Plan:
- Key 2b7e151628aed2a6abf7158809cf4f3c, start 1 cycle:
  - Required response: busy for 10 cycles, then done 1 cycle.
  - rk_idx=1 -> a0fafe1788542cb123a339392a6c7605.
  - rk_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
- Key 000102030405060708090a0b0c0d0e0f:
  - rk_idx=0 -> same value.
  - rk_idx=10 -> 13111d7fe3944a17f307a78b4d2b30c5.
- Key all zeros:
  - rk_idx=1 -> 62636363626363636263636362636363.
  - rk_idx=10 -> b4ef5bcb3e92e21123e951cf6f8f188e.
  - rk_idx=11 and rk_idx=15 -> 0.
- start with key A, then start with key B at cycle +4, key input toggled every cycle after the A start edge:
  - Required response: B is ignored, A's FIPS results are produced, done occurs exactly once at T+10.
- rst=0 at cycle +5 of an expansion:
  - Next cycle: busy=0, done=0, keys_valid=0, all rk read 0.
  - A following start on the key 2b7e1516... produces the correct schedule.
- Back-to-back expansions, start asserted in the cycle done is high:
  - Required response: keys_valid drops at that edge.
  - The second key's rk[10] is correct after 10 more cycles.
  - done pulses once per expansion.
